// File: rtl/timer_sched_pkg.sv
// Shared constants for the millisecond timer scheduler: default sizing and the
// prescaler width derived from the clock rate.
package timer_sched_pkg;

  localparam int DEF_CLK_PER_MS = 50000;
  localparam int DEF_NCH        = 4;
  localparam int DEF_CW         = 8;
  localparam int DEF_PRESCALE_W = $clog2(DEF_CLK_PER_MS);

  // Minimum-one-bit width for a counter or index that spans 0..v-1.
  function automatic int bits_for(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/timer_scheduler_if.sv
// Request/acknowledge bundle between requesters and the timer scheduler.
interface timer_scheduler_if
  import timer_sched_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CW  = DEF_CW
);

  logic [NCH-1:0]    req;
  logic [NCH*CW-1:0] delay_ms;
  logic [NCH-1:0]    abort;
  logic [NCH-1:0]    ack;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;
  logic              tick;

  modport master (
    output req, delay_ms, abort,
    input  ack, busy, done, tick
  );

  modport slave (
    input  req, delay_ms, abort,
    output ack, busy, done, tick
  );

endinterface

// File: rtl/ms_tick_gen.sv
// Shared millisecond prescaler: free-runs 0..CLK_PER_MS-1 while enabled and
// parks at 0 otherwise, pulsing tick on the last count of each period.
module ms_tick_gen
  import timer_sched_pkg::*;
#(
  parameter int CLK_PER_MS = DEF_CLK_PER_MS
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int            PW   = bits_for(CLK_PER_MS);
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_MS - 1);

  logic [PW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel millisecond delay scheduler: round-robin acceptance of
// requests, per-channel countdown on the shared tick, abort and done handling.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int CLK_PER_MS = DEF_CLK_PER_MS,
  parameter int NCH        = DEF_NCH,
  parameter int CW         = DEF_CW
) (
  input logic               clk,
  input logic               reset,
  timer_scheduler_if.slave  bus
);

  localparam int RRW = bits_for(NCH);

  logic [NCH-1:0] ack_q;
  logic [NCH-1:0] busy_q;
  logic [NCH-1:0] done_q;
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] grant;
  logic [CW-1:0]  remaining [NCH];
  logic [RRW-1:0] rr;
  logic [RRW-1:0] rr_next;
  logic           tick;

  ms_tick_gen #(
    .CLK_PER_MS (CLK_PER_MS)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (|busy_q),
    .tick   (tick)
  );

  // A channel still showing ack is excluded so a held req cannot double-grant.
  assign eligible = bus.req & ~busy_q & ~ack_q & ~bus.abort;

  always_comb begin : rr_pick
    int idx;
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    grant   = '0;
    rr_next = rr;
    idx     = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr) + k) % NCH;
      if ((grant == '0) && eligible[idx]) begin
        grant[idx] = 1'b1;
        rr_next    = RRW'((idx + 1) % NCH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_q  <= '0;
      busy_q <= '0;
      done_q <= '0;
      rr     <= '0;
      // NOTE: the counter array is real state that must start cleared, so it is reset element by element.
      for (int i = 0; i < NCH; i++) begin
        remaining[i] <= '0;
      end
    end else begin
      rr <= rr_next;
      for (int i = 0; i < NCH; i++) begin
        ack_q[i]  <= grant[i];
        done_q[i] <= 1'b0;
        if (bus.abort[i]) begin
          // Abort outranks both a pending grant and an expiring tick.
          busy_q[i]    <= 1'b0;
          remaining[i] <= '0;
        end else if (grant[i]) begin
          remaining[i] <= bus.delay_ms[i*CW +: CW];
          busy_q[i]    <= |bus.delay_ms[i*CW +: CW];
          done_q[i]    <= ~|bus.delay_ms[i*CW +: CW];
        end else if (busy_q[i] && tick) begin
          remaining[i] <= remaining[i] - 1'b1;
          if (remaining[i] == CW'(1)) begin
            busy_q[i] <= 1'b0;
            done_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.ack  = ack_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.tick = tick;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler at CLK_PER_MS=10, NCH=4, CW=8.
module tb_timer_scheduler;

  localparam int CPM = 10;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  timer_scheduler_if #(.NCH(NCH), .CW(CW)) bus ();

  timer_scheduler #(
    .CLK_PER_MS (CPM),
    .NCH        (NCH),
    .CW         (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land on the following falling edge for drive/sample.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_delay(input int ch, input int d);
    bus.delay_ms[ch*CW +: CW] = CW'(d);
  endtask

  int cyc;
  int ticks;
  int bad;
  int seen;
  int prev_rem;

  initial begin
    bus.req      = '0;
    bus.abort    = '0;
    bus.delay_ms = '0;

    // Reset state
    repeat (3) step();
    check("rst_ack",  32'(bus.ack),         32'h0);
    check("rst_busy", 32'(bus.busy),        32'h0);
    check("rst_done", 32'(bus.done),        32'h0);
    check("rst_tick", 32'(bus.tick),        32'h0);
    check("rst_rr",   32'(dut.rr),          32'h0);
    check("rst_cnt",  32'(dut.u_tick.cnt),  32'h0);
    reset = 1'b1;
    step();

    // All four channels request at once with zero delay: acks rotate 0..3
    for (int c = 0; c < NCH; c++) set_delay(c, 0);
    bus.req = 4'b1111;
    for (int k = 0; k < NCH; k++) begin
      step();
      check($sformatf("rr_ack%0d", k),  32'(bus.ack),  32'(1 << k));
      check($sformatf("rr_done%0d", k), 32'(bus.done), 32'(1 << k));
      bus.req[k] = 1'b0;
    end
    check("rr_wrap", 32'(dut.rr), 32'h0);
    step();
    check("rr_quiet_ack",  32'(bus.ack),  32'h0);
    check("rr_quiet_busy", 32'(bus.busy), 32'h0);

    // Single request ch0 delay 3 from idle: done exactly 30 cycles after ack
    set_delay(0, 3);
    bus.req[0] = 1'b1;
    step();
    check("d3_ack",  32'(bus.ack),  32'h1);
    check("d3_busy", 32'(bus.busy), 32'h1);
    bus.req[0] = 1'b0;
    cyc = 0; ticks = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      cyc++;
      if (bus.done[0]) break;
      if (bus.busy[0] !== 1'b1) bad++;
      if (bus.tick) ticks++;
    end
    check("d3_latency",  32'(cyc),       32'd30);
    check("d3_busy_gap", 32'(bad),       32'd0);
    check("d3_ticks",    32'(ticks),     32'd3);
    check("d3_done_busy", 32'(bus.busy), 32'h0);
    step();
    check("d3_done_pulse", 32'(bus.done),        32'h0);
    check("d3_cnt_idle",   32'(dut.u_tick.cnt),  32'h0);

    // ch2 delay 0: ack and done together, never busy, no tick
    set_delay(2, 0);
    bus.req[2] = 1'b1;
    step();
    check("d0_ack",  32'(bus.ack),  32'h4);
    check("d0_done", 32'(bus.done), 32'h4);
    check("d0_busy", 32'(bus.busy), 32'h0);
    bus.req[2] = 1'b0;
    bad = 0; ticks = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.busy[2]) bad++;
      if (bus.tick) ticks++;
    end
    check("d0_never_busy", 32'(bad),   32'd0);
    check("d0_no_tick",    32'(ticks), 32'd0);

    // ch1 delay 5, abort after the second tick
    set_delay(1, 5);
    bus.req[1] = 1'b1;
    step();
    check("ab_ack",  32'(bus.ack),  32'h2);
    check("ab_busy", 32'(bus.busy), 32'h2);
    bus.req[1] = 1'b0;
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.tick) ticks++;
      if (ticks == 2) break;
    end
    check("ab_two_ticks", 32'(ticks), 32'd2);
    step();
    bus.abort[1] = 1'b1;
    step();
    bus.abort[1] = 1'b0;
    check("ab_busy_fall", 32'(bus.busy), 32'h0);
    check("ab_no_done",   32'(bus.done), 32'h0);
    step();
    check("ab_cnt_zero", 32'(dut.u_tick.cnt), 32'h0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done[1]) seen++;
    end
    check("ab_no_late_done", 32'(seen), 32'd0);

    // Abort coinciding with the expiring tick wins
    set_delay(0, 1);
    bus.req[0] = 1'b1;
    step();
    check("co_ack", 32'(bus.ack), 32'h1);
    bus.req[0] = 1'b0;
    repeat (9) step();
    check("co_tick", 32'(bus.tick), 32'h1);
    bus.abort[0] = 1'b1;
    step();
    bus.abort[0] = 1'b0;
    check("co_no_done", 32'(bus.done),         32'h0);
    check("co_busy",    32'(bus.busy),         32'h0);
    check("co_rem",     32'(dut.remaining[0]), 32'h0);
    step();
    check("co_no_done2", 32'(bus.done), 32'h0);

    // Abort suppresses a same-cycle grant; channel grants once abort drops
    set_delay(3, 2);
    bus.req[3]   = 1'b1;
    bus.abort[3] = 1'b1;
    step();
    check("sup_no_ack", 32'(bus.ack), 32'h0);
    bus.abort[3] = 1'b0;
    step();
    check("sup_ack", 32'(bus.ack), 32'h8);
    bus.req[3]   = 1'b0;
    bus.abort[3] = 1'b1;
    step();
    bus.abort[3] = 1'b0;
    step();
    check("sup_idle", 32'(bus.busy), 32'h0);

    // Two channels counting, then reset mid-countdown
    set_delay(0, 4);
    bus.req[0] = 1'b1;
    step();
    check("rs_ack0", 32'(bus.ack), 32'h1);
    bus.req[0] = 1'b0;
    repeat (5) step();
    set_delay(3, 2);
    bus.req[3] = 1'b1;
    step();
    check("rs_ack3", 32'(bus.ack),  32'h8);
    check("rs_busy", 32'(bus.busy), 32'h9);
    bus.req[3] = 1'b0;
    repeat (7) step();
    reset = 1'b0;
    step();
    check("rs_ack0_out", 32'(bus.ack),          32'h0);
    check("rs_busy_out", 32'(bus.busy),         32'h0);
    check("rs_done_out", 32'(bus.done),         32'h0);
    check("rs_tick_out", 32'(bus.tick),         32'h0);
    check("rs_cnt",      32'(dut.u_tick.cnt),   32'h0);
    check("rs_rem0",     32'(dut.remaining[0]), 32'h0);
    check("rs_rem3",     32'(dut.remaining[3]), 32'h0);
    reset = 1'b1;
    seen = 0; bad = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.done != '0) seen++;
      if (bus.busy != '0) bad++;
    end
    check("rs_no_done", 32'(seen), 32'd0);
    check("rs_no_busy", 32'(bad),  32'd0);

    // Full-scale delay 255 on ch0
    set_delay(0, 255);
    bus.req[0] = 1'b1;
    step();
    check("max_ack", 32'(bus.ack),          32'h1);
    check("max_rem", 32'(dut.remaining[0]), 32'd255);
    bus.req[0] = 1'b0;
    cyc = 0; ticks = 0; bad = 0;
    prev_rem = 255;
    for (int i = 0; i < 2600; i++) begin
      step();
      cyc++;
      if (int'(dut.remaining[0]) > prev_rem) bad++;
      prev_rem = int'(dut.remaining[0]);
      if (bus.done[0]) break;
      if (bus.busy[0] !== 1'b1) bad++;
      if (bus.tick) ticks++;
    end
    check("max_latency", 32'(cyc),   32'd2550);
    check("max_ticks",   32'(ticks), 32'd255);
    check("max_no_wrap", 32'(bad),   32'd0);
    check("max_rem_end", 32'(dut.remaining[0]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
